// File: rtl/interlock_pkg.sv
// Shared route state encoding and the symmetric conflict-row helper for the interlock.
package interlock_pkg;

    typedef enum logic [1:0] {
        IDLE      = 2'd0,
        SETTING   = 2'd1,
        LOCKED    = 2'd2,
        RELEASING = 2'd3
    } route_state_t;

    localparam int MAX_ROUTES = 32;

    // Row i of the symmetric conflict relation; bits at and above n stay 0.
    function automatic logic [MAX_ROUTES-1:0] conflict_row(
        input logic [MAX_ROUTES*MAX_ROUTES-1:0] map,
        input int                               n,
        input int                               i
    );
        logic [MAX_ROUTES-1:0] row;
        row = '0;
        for (int j = 0; j < MAX_ROUTES; j++) begin
            if (j < n && j != i) begin
                row[j] = map[i*n+j] | map[j*n+i];
            end
        end
        return row;
    endfunction

endpackage

// File: rtl/route_fsm.sv
// One route's lifecycle: IDLE -> SETTING -> LOCKED -> RELEASING -> IDLE.
// Grant is registered; occupancy restarts the release timer.
module route_fsm
    import interlock_pkg::*;
#(
    parameter int SETUP_CYCLES   = 4,
    parameter int RELEASE_CYCLES = 16,
    parameter int CW             = 5
) (
    input  logic       i_clk,
    input  logic       i_rst_n,
    input  logic       start,
    input  logic       req,
    input  logic       cancel,
    input  logic       occupied,
    output logic [1:0] state,
    output logic       grant
);

    localparam logic [CW-1:0] SETUP_LD   = CW'(SETUP_CYCLES - 1);
    localparam logic [CW-1:0] RELEASE_LD = CW'(RELEASE_CYCLES - 1);

    route_state_t  state_q, state_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic          grant_q, grant_d;

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        grant_d = grant_q;
        unique case (state_q)
            IDLE: begin
                // A cancel arriving with an arbitration win keeps the route idle.
                if (start && !cancel) begin
                    state_d = SETTING;
                    cnt_d   = SETUP_LD;
                end
            end
            SETTING: begin
                if (cancel || !req) begin
                    state_d = IDLE;
                    cnt_d   = '0;
                end else if (cnt_q == '0) begin
                    state_d = LOCKED;
                    grant_d = 1'b1;
                end else begin
                    cnt_d = cnt_q - 1'b1;
                end
            end
            LOCKED: begin
                if (cancel || !req) begin
                    state_d = RELEASING;
                    cnt_d   = RELEASE_LD;
                    grant_d = 1'b0;
                end
            end
            RELEASING: begin
                if (occupied) begin
                    cnt_d = RELEASE_LD;
                end else if (cnt_q == '0) begin
                    state_d = IDLE;
                end else begin
                    cnt_d = cnt_q - 1'b1;
                end
            end
            default: begin
                state_d = IDLE;
                cnt_d   = '0;
                grant_d = 1'b0;
            end
        endcase
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            grant_q <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            grant_q <= grant_d;
        end
    end

    assign state = state_q;
    assign grant = grant_q;

endmodule

// File: rtl/route_interlock_ctrl.sv
// Route interlock: conflict check, round-robin start arbitration (one start per cycle), per-route FSMs.
// Grant SETUP_CYCLES+1 cycles after request; release needs RELEASE_CYCLES unoccupied cycles.
module route_interlock_ctrl
    import interlock_pkg::*;
#(
    parameter int                          N_ROUTES       = 8,
    parameter logic [N_ROUTES*N_ROUTES-1:0] CONFLICT_MAP  = '0,
    parameter int                          SETUP_CYCLES   = 4,
    parameter int                          RELEASE_CYCLES = 16
) (
    input  logic                i_clk,
    input  logic                i_rst_n,
    input  logic [N_ROUTES-1:0] i_req,
    input  logic [N_ROUTES-1:0] i_cancel,
    input  logic [N_ROUTES-1:0] i_occupied,
    output logic [N_ROUTES-1:0] o_grant,
    output logic [N_ROUTES-1:0] o_locked,
    output logic [N_ROUTES-1:0] o_denied,
    output logic                o_busy
);

    localparam int CNT_MAX = (SETUP_CYCLES > RELEASE_CYCLES) ? SETUP_CYCLES : RELEASE_CYCLES;
    localparam int CW      = $clog2(CNT_MAX + 1);
    localparam int PW      = $clog2(N_ROUTES);

    logic [1:0]                         route_st [N_ROUTES];
    logic [N_ROUTES-1:0]                active, blocked, eligible, start;
    logic [MAX_ROUTES*MAX_ROUTES-1:0]   map_ext;
    logic [MAX_ROUTES-1:0]              active_ext, row_tmp;
    logic [PW-1:0]                      ptr_q, ptr_d, win_idx;
    logic                               win_vld;
    int                                 arb_idx;

    always_comb begin
        for (int i = 0; i < N_ROUTES; i++) begin
            active[i] = (route_st[i] != IDLE);
        end
    end

    // A route is blocked while any route it conflicts with is outside IDLE.
    always_comb begin
        map_ext                         = '0;
        map_ext[N_ROUTES*N_ROUTES-1:0]  = CONFLICT_MAP;
        active_ext                      = '0;
        active_ext[N_ROUTES-1:0]        = active;
        row_tmp                         = '0;
        blocked                         = '0;
        for (int i = 0; i < N_ROUTES; i++) begin
            row_tmp    = conflict_row(map_ext, N_ROUTES, i);
            blocked[i] = |(row_tmp & active_ext);
        end
    end

    assign eligible = i_req & ~active & ~blocked;

    // Single winner per cycle, so two conflicting routes cannot start together.
    always_comb begin
        start   = '0;
        win_vld = 1'b0;
        win_idx = '0;
        arb_idx = 0;
        ptr_d   = ptr_q;
        for (int k = 0; k < N_ROUTES; k++) begin
            arb_idx = int'(ptr_q) + k;
            if (arb_idx >= N_ROUTES) begin
                arb_idx = arb_idx - N_ROUTES;
            end
            if (!win_vld && eligible[arb_idx]) begin
                win_vld = 1'b1;
                win_idx = PW'(arb_idx);
            end
        end
        if (win_vld) begin
            start[win_idx] = 1'b1;
            ptr_d          = (win_idx == PW'(N_ROUTES - 1)) ? '0 : win_idx + 1'b1;
        end
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            ptr_q <= '0;
        end else begin
            ptr_q <= ptr_d;
        end
    end

    for (genvar g = 0; g < N_ROUTES; g++) begin : g_route
        route_fsm #(
            .SETUP_CYCLES   (SETUP_CYCLES),
            .RELEASE_CYCLES (RELEASE_CYCLES),
            .CW             (CW)
        ) u_route_fsm (
            .i_clk    (i_clk),
            .i_rst_n  (i_rst_n),
            .start    (start[g]),
            .req      (i_req[g]),
            .cancel   (i_cancel[g]),
            .occupied (i_occupied[g]),
            .state    (route_st[g]),
            .grant    (o_grant[g])
        );
    end

    assign o_locked = active;
    assign o_denied = i_req & ~active & blocked;
    assign o_busy   = |active;

endmodule
